picture_load_ctrl: RTL and testbench

Write-side sequencer for the picture BRAM. Takes the byte stream from the UART receiver, packs three colour bytes into one 18-bit raw pixel, and issues one write per pixel in row-major order to port A of the picture memory. It asserts `loaded` once a full H_SIZE×V_SIZE frame is stored, and abandons a partial frame after an inter-byte timeout. It sits between the UART receiver and the BRAM inside the picture memory controller, in the 100 MHz base clock domain.

---
 rtl/picture_load_ctrl.sv | 159 +++++++++++++++
 tb/tb_picture_load_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/picture_load_ctrl.sv
// Picture BRAM write sequencer: packs R,G,B UART bytes into 18-bit pixels,
// writes them in row-major order, flags a full frame and drops stalled frames.
module picture_load_ctrl #(
    parameter int H_SIZE         = 607,
    parameter int V_SIZE         = 455,
    parameter int ADDR_W         = 19,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [17:0]       wr_data,
    output logic              busy,
    output logic              loaded,
    output logic              timeout,
    output logic [1:0]        dbg_state
);

    // Byte interface: rx_data is meaningful only in a cycle where rx_ready is
    // high; every such cycle is consumed, there is no back-pressure.

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_SIZE * V_SIZE - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [1:0]        ph, ph_d;
    logic [5:0]        r_lat, r_d;
    logic [5:0]        g_lat, g_d;
    logic [ADDR_W-1:0] pix, pix_d;
    logic [GAP_W-1:0]  gap, gap_d;
    logic              fin, fin_d;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [17:0]       wr_data_d;
    logic              loaded_d;
    logic              timeout_d;
    logic              unused_low_bits;

    assign unused_low_bits = ^rx_data[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ph      <= 2'd0;
            r_lat   <= 6'd0;
            g_lat   <= 6'd0;
            pix     <= '0;
            gap     <= '0;
            fin     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 18'd0;
            loaded  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_d;
            ph      <= ph_d;
            r_lat   <= r_d;
            g_lat   <= g_d;
            pix     <= pix_d;
            gap     <= gap_d;
            fin     <= fin_d;
            wr_en   <= wr_en_d;
            wr_addr <= wr_addr_d;
            wr_data <= wr_data_d;
            loaded  <= loaded_d;
            timeout <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state;
        ph_d      = ph;
        r_d       = r_lat;
        g_d       = g_lat;
        pix_d     = pix;
        gap_d     = gap;
        fin_d     = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        loaded_d  = loaded;
        timeout_d = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (rx_ready) begin
                    state_d  = RECV;
                    r_d      = rx_data[7:2];
                    ph_d     = 2'd1;
                    gap_d    = '0;
                    pix_d    = '0;
                    loaded_d = 1'b0;
                end
            end
            RECV: begin
                if (fin) begin
                    // Final write is on the bus this cycle; DONE and loaded
                    // follow it so busy falls exactly as loaded rises.
                    if (rx_ready) begin
                        r_d   = rx_data[7:2];
                        ph_d  = 2'd1;
                        gap_d = '0;
                        pix_d = '0;
                    end else begin
                        state_d  = DONE;
                        loaded_d = 1'b1;
                    end
                end else if (rx_ready) begin
                    gap_d = '0;
                    case (ph)
                        2'd1: begin
                            g_d  = rx_data[7:2];
                            ph_d = 2'd2;
                        end
                        2'd2: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = pix;
                            wr_data_d = {r_lat, g_lat, rx_data[7:2]};
                            ph_d      = 2'd0;
                            if (pix == LAST_PIX) begin
                                fin_d = 1'b1;
                            end else begin
                                pix_d = pix + 1'b1;
                            end
                        end
                        default: begin
                            r_d  = rx_data[7:2];
                            ph_d = 2'd1;
                        end
                    endcase
                end else if (gap == GAP_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    pix_d     = '0;
                    ph_d      = 2'd0;
                    gap_d     = '0;
                end else begin
                    gap_d = gap + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state == RECV);
    assign dbg_state = state;

endmodule

// File: tb/tb_picture_load_ctrl.sv
// Directed bench for picture_load_ctrl on a 4x2 frame with a 16-cycle timeout:
// a vector table for single-cycle behaviour plus sequences for frame-level cases.
module tb_picture_load_ctrl;

    localparam int H = 4;
    localparam int V = 2;
    localparam int AW = 3;
    localparam int TO = 16;
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [17:0]   wr_data;
    logic          busy;
    logic          loaded;
    logic          timeout;
    logic [1:0]    dbg_state;

    picture_load_ctrl #(
        .H_SIZE(H), .V_SIZE(V), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .loaded(loaded), .timeout(timeout), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int wr_count = 0;
    int to_count = 0;
    logic [AW+17:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every write pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (timeout) to_count++;
        if (wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {8'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                chk("write", {8'd0, wr_addr, wr_data}, {8'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input logic rdy, input logic [7:0] d);
        rx_ready = rdy;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic push_pix(input int n);
        logic [7:0] rb, gb, bb;
        rb = 8'(4 * n);
        gb = 8'(4 * n + 1);
        bb = 8'(4 * n + 2);
        exp_q.push_back({AW'(n), rb[7:2], gb[7:2], bb[7:2]});
    endtask

    // Sends bytes [first, first+count) of the standard frame pattern.
    task automatic send_bytes(input int first, input int count, input int gap_cycles);
        for (int i = first; i < first + count; i++) begin
            for (int g = 0; g < gap_cycles; g++) step(1'b0, 8'h00);
            step(1'b1, 8'(4 * (i / 3) + (i % 3)));
        end
    endtask

    task automatic frame_end(input string tag);
        chk({tag, "_last_wr_en"}, {31'd0, wr_en}, 1);
        chk({tag, "_busy_during_last"}, {31'd0, busy}, 1);
        step(1'b0, 8'h00);
        chk({tag, "_loaded"}, {31'd0, loaded}, 1);
        chk({tag, "_busy_after"}, {31'd0, busy}, 0);
        chk({tag, "_state_done"}, {30'd0, dbg_state}, 2);
    endtask

    task automatic do_reset(input string tag, input logic with_byte);
        reset = 1'b1;
        step(with_byte, 8'hFF);
        reset = 1'b0;
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 0);
        chk({tag, "_wr_addr"}, {29'd0, wr_addr}, 0);
        chk({tag, "_wr_data"}, {14'd0, wr_data}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_loaded"}, {31'd0, loaded}, 0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 0);
        chk({tag, "_state"}, {30'd0, dbg_state}, 0);
    endtask

    typedef struct {
        logic        rdy;
        logic [7:0]  d;
        logic        exp_wr_en;
        logic [2:0]  exp_addr;
        logic [17:0] exp_data;
        logic        exp_busy;
    } vec_t;

    vec_t vt[5];
    int   wr_base;

    initial begin
        vt[0] = '{rdy: 1'b1, d: 8'hFF, exp_wr_en: 1'b0, exp_addr: 3'd0, exp_data: 18'h00000, exp_busy: 1'b1};
        vt[1] = '{rdy: 1'b1, d: 8'h03, exp_wr_en: 1'b0, exp_addr: 3'd0, exp_data: 18'h00000, exp_busy: 1'b1};
        vt[2] = '{rdy: 1'b1, d: 8'h80, exp_wr_en: 1'b1, exp_addr: 3'd0, exp_data: 18'h3F020, exp_busy: 1'b1};
        vt[3] = '{rdy: 1'b0, d: 8'hAA, exp_wr_en: 1'b0, exp_addr: 3'd0, exp_data: 18'h3F020, exp_busy: 1'b1};
        vt[4] = '{rdy: 1'b1, d: 8'h44, exp_wr_en: 1'b0, exp_addr: 3'd0, exp_data: 18'h3F020, exp_busy: 1'b1};

        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        step(1'b0, 8'h00);
        do_reset("por", 1'b0);

        // Bit truncation via the vector table.
        exp_q.push_back({3'd0, 18'h3F020});
        for (int i = 0; i < 5; i++) begin
            step(vt[i].rdy, vt[i].d);
            chk($sformatf("vec%0d_wr_en", i), {31'd0, wr_en}, {31'd0, vt[i].exp_wr_en});
            chk($sformatf("vec%0d_wr_data", i), {14'd0, wr_data}, {14'd0, vt[i].exp_data});
            chk($sformatf("vec%0d_wr_addr", i), {29'd0, wr_addr}, {29'd0, vt[i].exp_addr});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].exp_busy});
        end
        do_reset("rst_a", 1'b0);

        // Full frame, back-to-back bytes.
        wr_base = wr_count;
        for (int n = 0; n < NPIX; n++) push_pix(n);
        send_bytes(0, 3 * NPIX, 0);
        frame_end("b2b");
        chk("b2b_write_count", wr_count - wr_base, NPIX);

        // DONE holds and the gap counter does not run.
        for (int i = 0; i < 2 * TO; i++) step(1'b0, 8'h00);
        chk("done_hold_loaded", {31'd0, loaded}, 1);
        chk("done_no_timeout", to_count, 0);

        // Reload after DONE.
        push_pix(0);
        send_bytes(0, 1, 0);
        chk("reload_loaded_fall", {31'd0, loaded}, 0);
        chk("reload_busy_rise", {31'd0, busy}, 1);
        send_bytes(1, 2, 0);
        chk("reload_wr_en", {31'd0, wr_en}, 1);
        chk("reload_addr", {29'd0, wr_addr}, 0);
        do_reset("rst_b", 1'b0);

        // Timeout mid-pixel.
        wr_base = wr_count;
        push_pix(0);
        push_pix(1);
        send_bytes(0, 7, 0);
        for (int i = 0; i < TO - 1; i++) step(1'b0, 8'h00);
        chk("pre_timeout_pulse", {31'd0, timeout}, 0);
        chk("pre_timeout_busy", {31'd0, busy}, 1);
        step(1'b0, 8'h00);
        chk("timeout_pulse", {31'd0, timeout}, 1);
        chk("timeout_busy", {31'd0, busy}, 0);
        chk("timeout_state", {30'd0, dbg_state}, 0);
        step(1'b0, 8'h00);
        chk("timeout_one_cycle", {31'd0, timeout}, 0);
        chk("timeout_count", to_count, 1);
        chk("timeout_writes", wr_count - wr_base, 2);
        for (int n = 0; n < NPIX; n++) push_pix(n);
        send_bytes(0, 3 * NPIX, 0);
        frame_end("after_to");
        do_reset("rst_c", 1'b0);

        // Gap boundary: each byte arrives in the expiry cycle.
        for (int n = 0; n < NPIX; n++) push_pix(n);
        send_bytes(0, 3 * NPIX, TO - 1);
        frame_end("gap");
        chk("gap_no_timeout", to_count, 1);
        do_reset("rst_d", 1'b0);

        // Reset mid-frame, with a byte colliding with reset.
        for (int n = 0; n < 3; n++) push_pix(n);
        send_bytes(0, 10, 0);
        do_reset("rst_mid", 1'b1);
        for (int n = 0; n < NPIX; n++) push_pix(n);
        send_bytes(0, 3 * NPIX, 0);
        frame_end("after_rst");

        step(1'b0, 8'h00);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
